// File: rtl/sd_adc_pkg.sv
// Shared definitions for the sigma-delta ADC capture path: warm-up state
// encoding and CIC sizing helpers derived from the decimation ratio.
package sd_adc_pkg;

  typedef enum logic [1:0] {
    WARM0 = 2'd0,
    WARM1 = 2'd1,
    RUN   = 2'd2
  } warm_state_e;

  // Accumulator width for a 2nd-order CIC fed with 1-bit data: log2(R^2)+1.
  function automatic int acc_width(input int decim_log2);
    return 2 * decim_log2 + 1;
  endfunction

  // Full-scale CIC output R^2, the single value that needs saturating.
  function automatic int r_squared(input int decim_log2);
    return 1 << (2 * decim_log2);
  endfunction

endpackage

// File: rtl/sd_adc_decimator_cic2.sv
// Second-order CIC decimator for a 1-bit stream. Integrators run every Clk,
// combs run once per R cycles. All arithmetic wraps modulo 2^A on purpose.
// ystrobe pulses the cycle after a decimation tick, while ys_top holds the
// saturated, truncated result of that tick.
module cic2_decimator
  import sd_adc_pkg::*;
#(
  parameter int DECIM_LOG2 = 6,
  parameter int OUT_W      = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             x,
  output logic             ystrobe,
  output logic [OUT_W-1:0] ys_top
);

  localparam int A  = acc_width(DECIM_LOG2);
  localparam int YW = 2 * DECIM_LOG2;
  localparam logic [A-1:0] RSQ = A'(r_squared(DECIM_LOG2));

  logic [A-1:0]          i1_r, i2_r, d1_r, d2_r, y_r;
  logic [DECIM_LOG2-1:0] cnt_r;
  logic                  tick_s;
  logic [A-1:0]          c1_s, y_s;
  logic [YW-1:0]         ys_s;

  assign tick_s = (cnt_r == {DECIM_LOG2{1'b1}});
  assign c1_s   = i2_r - d1_r;
  assign y_s    = c1_s - d2_r;

  // Integrators and the free-running decimation counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      i1_r  <= '0;
      i2_r  <= '0;
      cnt_r <= '0;
    end else begin
      i1_r  <= i1_r + {{(A-1){1'b0}}, x};
      i2_r  <= i2_r + i1_r;
      cnt_r <= cnt_r + {{(DECIM_LOG2-1){1'b0}}, 1'b1};
    end
  end

  // Comb stages and output capture, evaluated only on the decimation tick.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      d1_r    <= '0;
      d2_r    <= '0;
      y_r     <= '0;
      ystrobe <= 1'b0;
    end else begin
      ystrobe <= tick_s;
      if (tick_s) begin
        d1_r <= i2_r;
        d2_r <= c1_s;
        y_r  <= y_s;
      end else begin
        d1_r <= d1_r;
        d2_r <= d2_r;
        y_r  <= y_r;
      end
    end
  end

  // Clamp the single full-scale value R^2 so it fits in 2*DECIM_LOG2 bits.
  always_comb begin
    ys_s = y_r[YW-1:0];
    if (y_r >= RSQ) begin
      ys_s = {YW{1'b1}};
    end else begin
      ys_s = y_r[YW-1:0];
    end
  end

  assign ys_top = ys_s[YW-1 -: OUT_W];

endmodule

// File: rtl/sd_adc_decimator.sv
// Sigma-delta ADC front end: synchronizes the external comparator, closes the
// feedback loop on fb_out, decimates through a 2nd-order CIC and hands out
// excess-2^(OUT_W-1) samples over valid/ready with a sticky overrun flag.
// Build option: define SDADC_HYST_EN to give ear_out a Schmitt-trigger
// response (HYST_HI/HYST_LO); otherwise ear_out is the sample MSB.
module sd_adc_decimator
  import sd_adc_pkg::*;
#(
  parameter int               DECIM_LOG2 = 6,
  parameter int               OUT_W      = 8,
  parameter logic [OUT_W-1:0] HYST_HI    = 8'hA0,
  parameter logic [OUT_W-1:0] HYST_LO    = 8'h60
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             cmp_in,
  output logic             fb_out,
  output logic [OUT_W-1:0] sample_out,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             ear_out
);

  logic                s1_r, s2_r;
  logic                ystrobe_s;
  logic [OUT_W-1:0]    ys_top_s;
  logic                load_s;
  warm_state_e         state_r;

  // Two-flop synchronizer for the asynchronous comparator plus feedback flop.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_r   <= 1'b0;
      s2_r   <= 1'b0;
      fb_out <= 1'b0;
    end else begin
      s1_r   <= cmp_in;
      s2_r   <= s1_r;
      fb_out <= s2_r;
    end
  end

  cic2_decimator #(
    .DECIM_LOG2 (DECIM_LOG2),
    .OUT_W      (OUT_W)
  ) u_cic (
    .Clk     (Clk),
    .Reset   (Reset),
    .x       (s2_r),
    .ystrobe (ystrobe_s),
    .ys_top  (ys_top_s)
  );

  // The first two CIC outputs are built on unsettled comb history, so they
  // are discarded; state is judged at the strobe that delivers each output.
  assign load_s = ystrobe_s && (state_r == RUN);

  // Warm-up sequencer: one state per decimated output, RUN until Reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= WARM0;
    end else if (ystrobe_s) begin
      case (state_r)
        WARM0:   state_r <= WARM1;
        WARM1:   state_r <= RUN;
        RUN:     state_r <= RUN;
        default: state_r <= WARM0;
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  // Output register, valid/ready handshake and sticky overrun (set wins).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (load_s) begin
        sample_out   <= ys_top_s;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end else begin
        sample_valid <= sample_valid;
      end
      if (load_s && sample_valid && !sample_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end else begin
        overrun <= overrun;
      end
    end
  end

  // Tape-load level, refreshed from each newly loaded sample.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ear_out <= 1'b0;
    end else if (load_s) begin
`ifdef SDADC_HYST_EN
      if (ys_top_s >= HYST_HI) begin
        ear_out <= 1'b1;
      end else if (ys_top_s <= HYST_LO) begin
        ear_out <= 1'b0;
      end else begin
        ear_out <= ear_out;
      end
`else
      ear_out <= ys_top_s[OUT_W-1];
`endif
    end else begin
      ear_out <= ear_out;
    end
  end

endmodule

// File: tb/tb_sd_adc_decimator.sv
// Testbench for sd_adc_decimator. The reference model computes each CIC output
// directly as a triangular-weighted sum of the comparator history, then
// applies the warm-up, handshake and overrun rules to expected outputs.
module tb_sd_adc_decimator;

  localparam int DL    = 6;
  localparam int OW    = 8;
  localparam int R     = 1 << DL;
  localparam int RSQ   = R * R;
  localparam int HMAX  = 16384;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          cmp_in = 1'b0;
  logic          fb_out;
  logic [OW-1:0] sample_out;
  logic          sample_valid;
  logic          sample_ready = 1'b0;
  logic          overrun;
  logic          overrun_clr = 1'b0;
  logic          ear_out;

  int checks = 0;
  int errors = 0;

  // model state
  bit          hist [0:HMAX-1];
  int          e;
  int          ticks;
  bit          pend;
  bit          pend_keep;
  logic [7:0]  pend_val;
  logic        m_valid, m_ovr, m_ear, m_fb;
  logic [7:0]  m_sample;
  int          first_valid;

  sd_adc_decimator dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .cmp_in       (cmp_in),
    .fb_out       (fb_out),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr),
    .ear_out      (ear_out)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int cval(input int idx);
    if (idx < 0) return 0;
    return int'(hist[idx]);
  endfunction

  // CIC2 impulse response: triangle of length 2R-1 peaking at R.
  function automatic int tri_w(input int d);
    if (d <= 0 || d >= 2 * R) return 0;
    if (d <= R) return d;
    return 2 * R - d;
  endfunction

  // Expected sample for a decimation tick at edge k (3-edge pipeline to i2).
  function automatic logic [7:0] model_sample(input int k);
    int y = 0;
    for (int d = 1; d < 2 * R; d++) y += tri_w(d) * cval(k - 3 - d);
    if (y >= RSQ) y = RSQ - 1;
    return 8'((y >> (2 * DL - OW)) & 255);
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(sample_valid), 32'(m_valid));
    chk({tag, ".sample"}, 32'(sample_out), 32'(m_sample));
    chk({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    chk({tag, ".ear"}, 32'(ear_out), 32'(m_ear));
    chk({tag, ".fb"}, 32'(fb_out), 32'(m_fb));
  endtask

  task automatic step(input bit c, input bit rdy, input bit clr);
    bit load, ovset;
    cmp_in = c;
    sample_ready = rdy;
    overrun_clr = clr;
    hist[e] = c;
    @(posedge Clk);
    load  = pend && pend_keep;
    ovset = load && m_valid && !rdy;
    if (load) begin
      m_sample = pend_val;
      m_valid  = 1'b1;
`ifdef SDADC_HYST_EN
      if (pend_val >= 8'hA0) m_ear = 1'b1;
      else if (pend_val <= 8'h60) m_ear = 1'b0;
`else
      m_ear = pend_val[7];
`endif
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (ovset) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    m_fb = cval(e - 2) != 0;
    pend = 1'b0;
    if ((e % R) == R - 1) begin
      ticks++;
      pend      = 1'b1;
      pend_keep = (ticks >= 3);
      pend_val  = model_sample(e);
    end
    #1;
    check_all("cyc");
    if (first_valid < 0 && sample_valid === 1'b1) first_valid = e;
    e++;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    cmp_in = 1'b0;
    sample_ready = 1'b0;
    overrun_clr = 1'b0;
    @(posedge Clk);
    #1;
    chk("rst.valid", 32'(sample_valid), 32'd0);
    chk("rst.sample", 32'(sample_out), 32'd0);
    chk("rst.overrun", 32'(overrun), 32'd0);
    chk("rst.ear", 32'(ear_out), 32'd0);
    chk("rst.fb", 32'(fb_out), 32'd0);
    Reset = 1'b0;
    e = 0; ticks = 0; pend = 1'b0; pend_keep = 1'b0; pend_val = 8'h00;
    m_valid = 1'b0; m_ovr = 1'b0; m_ear = 1'b0; m_fb = 1'b0; m_sample = 8'h00;
    first_valid = -1;
  endtask

  initial begin
    // power-up reset
    do_reset();
    do_reset();

    // constant high input: first sample at the edge after the third tick
    for (int i = 0; i < 4 * R + 10; i++) step(1'b1, 1'b1, 1'b0);
    chk("hi.first_valid_edge", 32'(first_valid), 32'd192);
    chk("hi.sample_ff", 32'(sample_out), 32'hFF);
    chk("hi.ear", 32'(ear_out), 32'd1);

    // constant low input
    for (int i = 0; i < 4 * R; i++) step(1'b0, 1'b1, 1'b0);
    chk("lo.sample_00", 32'(sample_out), 32'h00);
    chk("lo.ear", 32'(ear_out), 32'd0);
    chk("lo.fb", 32'(fb_out), 32'd0);

    // toggling input settles at mid-scale
    for (int i = 0; i < 4 * R; i++) step(e[0], 1'b1, 1'b0);
    chk("tog.sample_80", 32'(sample_out), 32'h80);
    chk("tog.ear", 32'(ear_out), 32'd1);

    // consumer stalls across two loads -> overrun, newest sample held
    for (int i = 0; i < 2 * R + 4; i++) step(e[0], 1'b0, 1'b0);
    chk("ovr.set", 32'(overrun), 32'd1);
    chk("ovr.valid", 32'(sample_valid), 32'd1);
    chk("ovr.sample", 32'(sample_out), 32'h80);
    step(e[0], 1'b0, 1'b1);
    chk("ovr.cleared", 32'(overrun), 32'd0);
    // clear coinciding with a new overrun: set wins
    for (int i = 0; i < R + 2 && (e % R) != 0; i++) step(e[0], 1'b0, 1'b0);
    step(e[0], 1'b0, 1'b1);
    chk("ovr.set_wins", 32'(overrun), 32'd1);

    // randomized input density, ready and clear
    for (int i = 0; i < 10 * R; i++) begin
      step(($urandom_range(0, 99) < (i / R) * 10) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 6 * R; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    // stall to hold a valid sample, then reset mid-run
    for (int i = 0; i < R + 2; i++) step(1'b1, 1'b0, 1'b0);
    chk("mid.valid_before", 32'(sample_valid), 32'd1);
    do_reset();
    for (int i = 0; i < 3 * R + 8; i++) step(1'b1, 1'b1, 1'b0);
    chk("mid.first_valid_edge", 32'(first_valid), 32'd192);
    chk("mid.sample_ff", 32'(sample_out), 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
